// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: per-instruction state sequencing, memory-ready wait with timeout, trap on illegal/timeout.
// Optional retired-instruction counter enabled by defining CU_PERF_CNT_EN.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [5:0]            op_in,
  input  logic [5:0]            func_in,
  input  logic                  zero_in,
  input  logic                  mem_ready_in,
  output logic                  pcWrite_out,
  output logic [1:0]            pcSrc_out,
  output logic                  irWrite_out,
  output logic                  iorD_out,
  output logic                  memRead_out,
  output logic                  memWrite_out,
  output logic                  regWrite_out,
  output logic                  regDst_out,
  output logic                  memToReg_out,
  output logic                  ALUSrcA_out,
  output logic [1:0]            ALUSrcB_out,
  output logic [ALU_CTRL_W-1:0] ALUCntrl_out,
  output logic [3:0]            state_out,
  output logic                  instr_done_out,
  output logic                  trap_out,
  output logic [1:0]            trap_cause_out,
  output logic [31:0]           retired_cnt_out
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11, S_TRAP = 4'd12
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d, func_q, func_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [3:0]    alu;
  logic          wait_st, to_hit;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign to_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST) && !mem_ready_in;

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    func_d = func_q;
    cause_d = cause_q;
    alu = 4'b0000;
    wait_st = 1'b0;
    pcWrite_out = 1'b0;
    pcSrc_out = 2'b00;
    irWrite_out = 1'b0;
    iorD_out = 1'b0;
    memRead_out = 1'b0;
    memWrite_out = 1'b0;
    regWrite_out = 1'b0;
    regDst_out = 1'b0;
    memToReg_out = 1'b0;
    ALUSrcA_out = 1'b0;
    ALUSrcB_out = 2'b00;
    instr_done_out = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead_out = 1'b1;
        ALUSrcB_out = 2'b01;
        irWrite_out = mem_ready_in;
        pcWrite_out = mem_ready_in;
        wait_st = 1'b1;
        if (mem_ready_in) state_d = S_DECODE;
        else if (to_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
      end
      S_DECODE: begin
        op_d = op_in;
        func_d = func_in;
        ALUSrcB_out = 2'b11;
        case (op_in)
          6'b000000: begin
            case (func_in)
              6'b000000: begin state_d = S_FETCH; instr_done_out = 1'b1; end
              6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: state_d = S_R_EXEC;
              default: begin state_d = S_TRAP; cause_d = 2'b01; end
            endcase
          end
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b001000: state_d = S_I_EXEC;
          6'b000100: state_d = S_BRANCH;
          6'b000010: state_d = S_JUMP;
          default: begin state_d = S_TRAP; cause_d = 2'b01; end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA_out = 1'b1;
        ALUSrcB_out = 2'b10;
        state_d = (op_q == 6'b100011) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iorD_out = 1'b1;
        memRead_out = 1'b1;
        wait_st = 1'b1;
        if (mem_ready_in) state_d = S_MEM_WB;
        else if (to_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
      end
      S_MEM_WB: begin
        regWrite_out = 1'b1;
        memToReg_out = 1'b1;
        instr_done_out = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        iorD_out = 1'b1;
        memWrite_out = 1'b1;
        wait_st = 1'b1;
        if (mem_ready_in) begin state_d = S_FETCH; instr_done_out = 1'b1; end
        else if (to_hit) begin state_d = S_TRAP; cause_d = 2'b10; end
      end
      S_R_EXEC: begin
        ALUSrcA_out = 1'b1;
        case (func_q)
          6'b100010: alu = 4'b0001;
          6'b100100: alu = 4'b0010;
          6'b100101: alu = 4'b0101;
          6'b101010: alu = 4'b0100;
          default:   alu = 4'b0000;
        endcase
        state_d = S_R_WB;
      end
      S_R_WB: begin
        regWrite_out = 1'b1;
        regDst_out = 1'b1;
        instr_done_out = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA_out = 1'b1;
        ALUSrcB_out = 2'b10;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        regWrite_out = 1'b1;
        instr_done_out = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_out = 1'b1;
        alu = 4'b0001;
        pcSrc_out = 2'b01;
        pcWrite_out = zero_in;
        instr_done_out = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcSrc_out = 2'b10;
        pcWrite_out = 1'b1;
        instr_done_out = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
    // Any state change is an entry, so the wait counter restarts from zero.
    if (state_d != state_q) cnt_d = '0;
    else if (wait_st && !mem_ready_in) cnt_d = cnt_q + CW'(1);
    else cnt_d = cnt_q;
  end

  assign ALUCntrl_out   = ALU_CTRL_W'(alu);
  assign state_out      = state_q;
  assign trap_out       = (state_q == S_TRAP);
  assign trap_cause_out = cause_q;

`ifdef CU_PERF_CNT_EN
  logic [31:0] ret_q;
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) ret_q <= '0;
    else if (instr_done_out) ret_q <= ret_q + 32'd1;
  end
  assign retired_cnt_out = ret_q;
`else
  assign retired_cnt_out = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction vector table plus reset/timeout/trap sequences, checked per cycle against a model.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, zero, rdy;
  logic [5:0] op, func;
  logic pcW, irW, iorD, mR, mW, rW, rD, m2r, aA, done, trap;
  logic [1:0] pcSrc, aB, cause;
  logic [3:0] alu, st;
  logic [31:0] ret;

  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
    .clk_in(clk), .reset_in(rst), .op_in(op), .func_in(func), .zero_in(zero),
    .mem_ready_in(rdy), .pcWrite_out(pcW), .pcSrc_out(pcSrc), .irWrite_out(irW),
    .iorD_out(iorD), .memRead_out(mR), .memWrite_out(mW), .regWrite_out(rW),
    .regDst_out(rD), .memToReg_out(m2r), .ALUSrcA_out(aA), .ALUSrcB_out(aB),
    .ALUCntrl_out(alu), .state_out(st), .instr_done_out(done), .trap_out(trap),
    .trap_cause_out(cause), .retired_cnt_out(ret)
  );

  typedef struct packed {
    logic pcW; logic [1:0] pcSrc; logic irW, iorD, mR, mW, rW, rD, m2r, aA;
    logic [1:0] aB; logic [3:0] alu; logic [3:0] st; logic done, trap; logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic [5:0] op, func; logic zero; logic [3:0] wst; int nwait; int ncyc;
    logic trap; logic [1:0] cause;
  } vec_t;

  outs_t act;
  assign act = {pcW, pcSrc, irW, iorD, mR, mW, rW, rD, m2r, aA, aB, alu, st, done, trap, cause};

`ifdef CU_PERF_CNT_EN
  localparam logic [31:0] RET3 = 32'd3;
`else
  localparam logic [31:0] RET3 = 32'd0;
`endif

  int nvec = 0, nerr = 0;
  outs_t sb[$];
  logic [3:0] m_state;
  logic [5:0] m_op, m_func;
  int m_cnt;
  logic [1:0] m_cause;

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 4'b0001;
      6'b100100: return 4'b0010;
      6'b100101: return 4'b0101;
      6'b101010: return 4'b0100;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic outs_t m_outs();
    outs_t o;
    o = '0;
    o.st = m_state;
    case (m_state)
      4'd0:  begin o.mR = 1; o.aB = 2'b01; o.irW = rdy; o.pcW = rdy; end
      4'd1:  begin o.aB = 2'b11; o.done = (op == 6'd0 && func == 6'd0); end
      4'd2:  begin o.aA = 1; o.aB = 2'b10; end
      4'd3:  begin o.iorD = 1; o.mR = 1; end
      4'd4:  begin o.rW = 1; o.m2r = 1; o.done = 1; end
      4'd5:  begin o.iorD = 1; o.mW = 1; o.done = rdy; end
      4'd6:  begin o.aA = 1; o.alu = alu_of(m_func); end
      4'd7:  begin o.rW = 1; o.rD = 1; o.done = 1; end
      4'd8:  begin o.aA = 1; o.alu = 4'b0001; o.pcSrc = 2'b01; o.pcW = zero; o.done = 1; end
      4'd9:  begin o.pcSrc = 2'b10; o.pcW = 1; o.done = 1; end
      4'd10: begin o.aA = 1; o.aB = 2'b10; end
      4'd11: begin o.rW = 1; o.done = 1; end
      4'd12: begin o.trap = 1; o.cause = m_cause; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic m_wait(input logic [3:0] nxt, inout logic [3:0] ns);
    if (rdy) ns = nxt;
    else if (m_cnt == 3) begin ns = 4'd12; m_cause = 2'b10; end
    else m_cnt++;
  endtask

  task automatic m_step();
    logic [3:0] ns;
    ns = m_state;
    case (m_state)
      4'd0: m_wait(4'd1, ns);
      4'd1: begin
        m_op = op; m_func = func;
        if (op == 6'd0) begin
          if (func == 6'd0) ns = 4'd0;
          else if (func inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ns = 4'd6;
          else begin ns = 4'd12; m_cause = 2'b01; end
        end else if (op == 6'b100011 || op == 6'b101011) ns = 4'd2;
        else if (op == 6'b001000) ns = 4'd10;
        else if (op == 6'b000100) ns = 4'd8;
        else if (op == 6'b000010) ns = 4'd9;
        else begin ns = 4'd12; m_cause = 2'b01; end
      end
      4'd2: ns = (m_op == 6'b100011) ? 4'd3 : 4'd5;
      4'd3: m_wait(4'd4, ns);
      4'd5: m_wait(4'd0, ns);
      4'd6: ns = 4'd7;
      4'd10: ns = 4'd11;
      4'd12: ns = 4'd12;
      default: ns = 4'd0;
    endcase
    if (ns != m_state) m_cnt = 0;
    m_state = ns;
  endtask

  task automatic check(input string tag, input outs_t a, input outs_t e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, a, e, $time);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic r, input logic z, input string tag, output outs_t e);
    rdy = r; zero = z;
    #2;
    e = m_outs();
    sb.push_back(e);
    check(tag, act, sb.pop_front());
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    outs_t e;
    rst = 1; rdy = 0; zero = 0; op = 0; func = 0;
    #2;
    e = '0; e.mR = 1; e.aB = 2'b01;
    check("reset_outs", act, e);
    nvec++;
    if (ret !== 32'd0) begin nerr++; $display("FAIL reset_ret: got %0d expected 0", ret); end
    @(negedge clk);
    rst = 0;
    m_state = 0; m_op = 0; m_func = 0; m_cnt = 0; m_cause = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit rst_first);
    outs_t e;
    int cyc, waited;
    bit fin;
    logic r;
    if (rst_first) do_reset();
    op = v.op; func = v.func;
    cyc = 0; waited = 0; fin = 0;
    while (!fin && cyc < 40) begin
      r = 1;
      if (m_state == v.wst && waited < v.nwait) begin r = 0; waited++; end
      step(r, v.zero, tag, e);
      cyc++;
      fin = e.done || (m_state == 4'd12);
    end
    nvec++;
    if (cyc != v.ncyc || trap !== v.trap || (v.trap && cause !== v.cause)) begin
      nerr++;
      $display("FAIL %s_len: got cyc=%0d trap=%b cause=%b expected cyc=%0d trap=%b cause=%b",
               tag, cyc, trap, cause, v.ncyc, v.trap, v.cause);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input logic [3:0] w, input int nw, input int nc,
                              input logic t, input logic [1:0] c);
    vec_t v;
    v.op = o; v.func = f; v.zero = z; v.wst = w; v.nwait = nw; v.ncyc = nc; v.trap = t; v.cause = c;
    return v;
  endfunction

  vec_t tbl[19];
  string nm[19];

  initial begin
    outs_t e;
    tbl[0]  = mk(6'b000000, 6'b100000, 0, 0, 0, 4, 0, 0);  nm[0]  = "add";
    tbl[1]  = mk(6'b000000, 6'b100010, 0, 0, 0, 4, 0, 0);  nm[1]  = "sub";
    tbl[2]  = mk(6'b000000, 6'b100100, 0, 0, 0, 4, 0, 0);  nm[2]  = "and";
    tbl[3]  = mk(6'b000000, 6'b100101, 0, 0, 0, 4, 0, 0);  nm[3]  = "or";
    tbl[4]  = mk(6'b000000, 6'b101010, 0, 0, 0, 4, 0, 0);  nm[4]  = "slt";
    tbl[5]  = mk(6'b000000, 6'b000000, 0, 0, 0, 2, 0, 0);  nm[5]  = "nop";
    tbl[6]  = mk(6'b100011, 6'b000000, 0, 3, 3, 8, 0, 0);  nm[6]  = "lw_wait3";
    tbl[7]  = mk(6'b100011, 6'b000000, 0, 3, 0, 5, 0, 0);  nm[7]  = "lw";
    tbl[8]  = mk(6'b101011, 6'b000000, 0, 5, 1, 5, 0, 0);  nm[8]  = "sw_wait1";
    tbl[9]  = mk(6'b001000, 6'b000000, 0, 0, 0, 4, 0, 0);  nm[9]  = "addi";
    tbl[10] = mk(6'b000100, 6'b000000, 1, 0, 0, 3, 0, 0);  nm[10] = "beq_taken";
    tbl[11] = mk(6'b000100, 6'b000000, 0, 0, 0, 3, 0, 0);  nm[11] = "beq_not";
    tbl[12] = mk(6'b000010, 6'b000000, 0, 0, 0, 3, 0, 0);  nm[12] = "j";
    tbl[13] = mk(6'b111111, 6'b000000, 0, 0, 0, 2, 1, 1);  nm[13] = "ill_op";
    tbl[14] = mk(6'b000000, 6'b000111, 0, 0, 0, 2, 1, 1);  nm[14] = "ill_func";
    tbl[15] = mk(6'b000000, 6'b100000, 0, 0, 2, 6, 0, 0);  nm[15] = "add_fwait2";
    tbl[16] = mk(6'b000000, 6'b000000, 0, 0, 4, 4, 1, 2);  nm[16] = "fetch_to";
    tbl[17] = mk(6'b000000, 6'b000000, 0, 0, 3, 5, 0, 0);  nm[17] = "fetch_rdy4";
    tbl[18] = mk(6'b100011, 6'b000000, 0, 3, 4, 7, 1, 2);  nm[18] = "mrd_to";

    rst = 1; rdy = 0; zero = 0; op = 0; func = 0;
    m_state = 0; m_op = 0; m_func = 0; m_cnt = 0; m_cause = 0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) run_vec(tbl[i], nm[i], 1'b1);

    // Illegal encoding trap must hold for 20 cycles regardless of inputs.
    run_vec(tbl[13], "ill_hold", 1'b1);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(1)), 1'($urandom_range(1)), "trap_hold", e);
    nvec++;
    if (trap !== 1'b1 || cause !== 2'b01 || st !== 4'd12) begin
      nerr++; $display("FAIL trap_held: got trap=%b cause=%b st=%0d expected 1 01 12", trap, cause, st);
    end

    // Asynchronous reset while in MEM_WRITE.
    do_reset();
    op = 6'b101011; func = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "sw_pre", e);
    rdy = 0;
    #2;
    nvec++;
    if (mW !== 1'b1 || st !== 4'd5) begin nerr++; $display("FAIL sw_in_mw: got mW=%b st=%0d expected 1 5", mW, st); end
    rst = 1;
    #1;
    nvec++;
    if (mW !== 1'b0 || st !== 4'd0) begin nerr++; $display("FAIL async_rst: got mW=%b st=%0d expected 0 0", mW, st); end
    @(negedge clk);
    rst = 0;
    m_state = 0; m_op = 0; m_func = 0; m_cnt = 0; m_cause = 0;

    // Three back-to-back NOPs for the retirement counter.
    do_reset();
    for (int i = 0; i < 3; i++) run_vec(tbl[5], "nop_cnt", 1'b0);
    nvec++;
    if (ret !== RET3) begin nerr++; $display("FAIL retired: got %0d expected %0d", ret, RET3); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
